// File: rtl/b12_stim_sequencer.sv
// b12_stim_sequencer
// Stimulus player that feeds the b12 game core. A small program of 6-bit
// opcodes (bit 5 = obs, bits 4:1 = k, bit 0 = start) is written while idle.
// Once started, the player issues one opcode per clock. It supports loop,
// stop and done reporting.
//
// Ports:
//   clock            single clock, rising edge
//   reset            synchronous active-high reset
//   wr_en/addr/data  program-memory write (honoured in IDLE/DONE only)
//   len              program length 0..DEPTH, clamped, latched on run
//   loop             wrap after last entry, latched on run
//   run, stop        start / abort requests (stop has priority)
//   k, start, obs    registered opcode fields driven to the core
//   pc               address of the next entry to issue
//   busy, done       PLAY / DONE status
//   wr_err           one-cycle pulse for a write attempted during PLAY
//   issued           saturating count of opcodes issued since last run
module b12_stim_sequencer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [5:0]    wr_data,
    input  logic [AW:0]   len,
    input  logic          loop,
    input  logic          run,
    input  logic          stop,
    output logic [3:0]    k,
    output logic          start,
    output logic          obs,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          done,
    output logic          wr_err,
    output logic [15:0]   issued
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t        state_r, state_s;
    logic [AW-1:0] pc_r, pc_s;
    logic [AW:0]   len_r, len_s;
    logic          loop_r, loop_s;
    logic [5:0]    op_r, op_s;
    logic [15:0]   issued_r, issued_s;
    logic          wr_err_r, wr_err_s;
    logic          mem_we_s;
    logic [AW:0]   run_len_s;
    logic [5:0]    mem_r [DEPTH];

    // Lengths above DEPTH would run off the end of the memory.
    function automatic logic [AW:0] clamp_len(input logic [AW:0] l);
        if (l > (AW+1)'(DEPTH)) begin
            return (AW+1)'(DEPTH);
        end else begin
            return l;
        end
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end else begin
            return v + 16'd1;
        end
    endfunction

    // Next-state and next-output logic for the player FSM.
    always_comb begin
        state_s   = state_r;
        pc_s      = pc_r;
        len_s     = len_r;
        loop_s    = loop_r;
        op_s      = 6'd0;
        issued_s  = issued_r;
        wr_err_s  = 1'b0;
        mem_we_s  = 1'b0;
        run_len_s = clamp_len(len);
        case (state_r)
            ST_PLAY: begin
                wr_err_s = wr_en;
                if (stop) begin
                    // Abort without issuing; pc keeps the unissued entry.
                    state_s = ST_IDLE;
                end else begin
                    op_s     = mem_r[pc_r];
                    issued_s = sat_inc(issued_r);
                    if ({1'b0, pc_r} == len_r - (AW+1)'(1)) begin
                        if (loop_r) begin
                            pc_s = '0;
                        end else begin
                            state_s = ST_DONE;
                        end
                    end else begin
                        pc_s = pc_r + AW'(1);
                    end
                end
            end
            ST_IDLE, ST_DONE: begin
                // The memory write lands on the same edge a run is accepted,
                // and the first read happens one edge later, so it is seen.
                mem_we_s = wr_en;
                if (stop) begin
                    state_s = ST_IDLE;
                end else if (run) begin
                    len_s    = run_len_s;
                    loop_s   = loop;
                    issued_s = 16'd0;
                    if (run_len_s != (AW+1)'(0)) begin
                        state_s = ST_PLAY;
                        pc_s    = '0;
                    end else begin
                        state_s = ST_DONE;
                    end
                end else begin
                    state_s = state_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            pc_r     <= '0;
            len_r    <= '0;
            loop_r   <= 1'b0;
            op_r     <= 6'd0;
            issued_r <= 16'd0;
            wr_err_r <= 1'b0;
        end else begin
            state_r  <= state_s;
            pc_r     <= pc_s;
            len_r    <= len_s;
            loop_r   <= loop_s;
            op_r     <= op_s;
            issued_r <= issued_s;
            wr_err_r <= wr_err_s;
        end
    end

    // Program memory; deliberately not cleared by reset.
    always_ff @(posedge clock) begin
        if (mem_we_s) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign obs    = op_r[5];
    assign k      = op_r[4:1];
    assign start  = op_r[0];
    assign pc     = pc_r;
    assign busy   = (state_r == ST_PLAY);
    assign done   = (state_r == ST_DONE);
    assign wr_err = wr_err_r;
    assign issued = issued_r;

endmodule

// File: tb/tb_b12_stim_sequencer.sv
module tb_b12_stim_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = 4'd0;
    logic [5:0]  wr_data = 6'd0;
    logic [4:0]  len = 5'd0;
    logic        loop = 1'b0;
    logic        run = 1'b0;
    logic        stop = 1'b0;
    logic [3:0]  k;
    logic        start;
    logic        obs;
    logic [3:0]  pc;
    logic        busy;
    logic        done;
    logic        wr_err;
    logic [15:0] issued;

    b12_stim_sequencer #(.DEPTH(16), .AW(4)) dut (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .len(len), .loop(loop), .run(run), .stop(stop),
        .k(k), .start(start), .obs(obs), .pc(pc), .busy(busy), .done(done),
        .wr_err(wr_err), .issued(issued)
    );

    always #5 clock = ~clock;

    int passed = 0;
    int total  = 0;

    // Behavioural model: a program of L entries is issued in order; the n-th
    // issue (0-based) plays entry n mod L.
    logic [5:0] mmem [16];
    bit         m_play = 1'b0;
    bit         m_done = 1'b0;
    bit         m_lp   = 1'b0;
    bit         m_werr = 1'b0;
    int         m_n    = 0;
    int         m_L    = 0;
    int         m_pc   = 0;
    int         m_iss  = 0;
    logic [5:0] m_op   = 6'd0;

    wire [5:0] dut_op = {obs, k, start};

    task automatic model_step();
        if (reset) begin
            m_play = 0; m_done = 0; m_pc = 0; m_op = 6'd0; m_iss = 0; m_werr = 0; m_n = 0;
        end else if (m_play) begin
            m_werr = wr_en;
            if (stop) begin
                m_play = 0;
                m_op = 6'd0;
            end else begin
                m_op = mmem[m_n % m_L];
                m_n = m_n + 1;
                m_iss = (m_n > 65535) ? 65535 : m_n;
                if (!m_lp && m_n == m_L) begin
                    m_play = 0;
                    m_done = 1;
                    m_pc = m_L - 1;
                end else begin
                    m_pc = m_n % m_L;
                end
            end
        end else begin
            m_werr = 0;
            m_op = 6'd0;
            if (wr_en) mmem[wr_addr] = wr_data;
            if (stop) begin
                m_done = 0;
            end else if (run) begin
                m_L = (int'(len) > 16) ? 16 : int'(len);
                m_lp = loop;
                m_n = 0;
                m_iss = 0;
                if (m_L > 0) begin
                    m_play = 1; m_done = 0; m_pc = 0;
                end else begin
                    m_done = 1;
                end
            end
        end
    endtask

    // One clock: model follows the edge, then every output is compared.
    task automatic tick();
        logic [32:0] act, expv;
        @(posedge clock);
        model_step();
        #1;
        act  = {dut_op, pc, busy, done, wr_err, issued, 4'd0};
        expv = {m_op, 4'(m_pc), m_play, m_done, m_werr, 16'(m_iss), 4'd0};
        total++;
        if (act !== expv) begin
            $display("FAIL cyc t=%0t got op=%h pc=%0d busy=%b done=%b werr=%b iss=%0d want op=%h pc=%0d busy=%b done=%b werr=%b iss=%0d",
                     $time, dut_op, pc, busy, done, wr_err, issued,
                     m_op, m_pc, m_play, m_done, m_werr, m_iss);
        end else begin
            passed++;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            $display("FAIL %s got %0h want %0h", nm, act, expv);
        end else begin
            passed++;
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [5:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic go(input logic [4:0] l, input logic lp);
        len = l; loop = lp; run = 1'b1;
        tick();
        run = 1'b0;
    endtask

    logic [5:0] prog [3];
    int         seq_idx [7];

    initial begin
        prog[0] = 6'b000011; prog[1] = 6'b100100; prog[2] = 6'b011111;
        seq_idx[0] = 0; seq_idx[1] = 1; seq_idx[2] = 2; seq_idx[3] = 0;
        seq_idx[4] = 1; seq_idx[5] = 2; seq_idx[6] = 0;

        // Reset state
        reset = 1'b1; tick(); tick(); reset = 1'b0;
        chk("rst_op", 32'(dut_op), 32'd0);
        chk("rst_busy_done", {30'd0, busy, done}, 32'd0);
        chk("rst_issued", 32'(issued), 32'd0);
        chk("rst_pc", 32'(pc), 32'd0);

        // Fill memory, then the 3-entry program
        for (int i = 0; i < 16; i++) wr(4'(i), 6'($urandom_range(0, 63)));
        for (int i = 0; i < 3; i++) wr(4'(i), prog[i]);

        // Load and play
        go(5'd3, 1'b0);
        chk("play_busy_e0", 32'(busy), 32'd1);
        tick(); chk("play_e1", 32'(dut_op), 32'b000011);
        tick(); chk("play_e2", 32'(dut_op), 32'b100100);
        tick(); chk("play_e3", 32'(dut_op), 32'b011111);
        chk("play_done", 32'(done), 32'd1);
        chk("play_issued", 32'(issued), 32'd3);
        tick(); chk("play_e4_zero", 32'(dut_op), 32'd0);

        // Loop mode
        go(5'd3, 1'b1);
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("loop_seq", 32'(dut_op), 32'(prog[seq_idx[i]]));
            chk("loop_nodone", 32'(done), 32'd0);
        end
        chk("loop_issued", 32'(issued), 32'd7);
        stop = 1'b1; tick(); stop = 1'b0;

        // Stop mid-program
        go(5'd8, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        stop = 1'b1; tick(); stop = 1'b0;
        chk("stop_busy", {30'd0, busy, done}, 32'd0);
        chk("stop_op", 32'(dut_op), 32'd0);
        chk("stop_issued", 32'(issued), 32'd4);
        chk("stop_pc", 32'(pc), 32'd4);

        // Zero length
        go(5'd0, 1'b0);
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_issued", 32'(issued), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("zero_op", 32'(dut_op), 32'd0);
        end

        // Write during PLAY
        go(5'd3, 1'b0);
        wr_en = 1'b1; wr_addr = 4'd1; wr_data = 6'h3F;
        tick();
        wr_en = 1'b0;
        chk("wrerr_pulse", 32'(wr_err), 32'd1);
        tick();
        chk("wrerr_clear", 32'(wr_err), 32'd0);
        chk("wrerr_old", 32'(dut_op), 32'b100100);
        tick(); tick();

        // Reset mid-PLAY and restart
        go(5'd3, 1'b0);
        tick(); tick();
        reset = 1'b1; run = 1'b1; tick(); reset = 1'b0; run = 1'b0;
        chk("mid_rst_op", 32'(dut_op), 32'd0);
        chk("mid_rst_stat", {30'd0, busy, done}, 32'd0);
        chk("mid_rst_issued", 32'(issued), 32'd0);
        go(5'd3, 1'b0);
        tick(); chk("replay_e1", 32'(dut_op), 32'b000011);
        tick(); tick(); tick();
        go(5'd3, 1'b0);
        tick(); chk("redone_e1", 32'(dut_op), 32'b000011);
        tick(); tick();

        // Randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            reset   = ($urandom_range(0, 299) == 0);
            stop    = ($urandom_range(0, 19) == 0);
            run     = ($urandom_range(0, 5) == 0);
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_addr = 4'($urandom_range(0, 15));
            wr_data = 6'($urandom_range(0, 63));
            len     = 5'($urandom_range(0, 31));
            loop    = 1'($urandom_range(0, 1));
            tick();
        end
        reset = 1'b0; stop = 1'b1; run = 1'b0; wr_en = 1'b0; tick(); stop = 1'b0;

        // Saturation of issued with a clamped-length looping program
        go(5'd31, 1'b1);
        for (int c = 0; c < 65540; c++) tick();
        chk("sat_issued", 32'(issued), 32'h0000FFFF);
        chk("sat_busy", 32'(busy), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
